// File: rtl/mac_dot_engine.sv
// -----------------------------------------------------------------------------
// mac_dot_engine
//
// Pipelined multiply-accumulate engine that streams dot products. Each term
// (a * b) is added to or subtracted from a running accumulator. The term marked
// "last" closes the frame. The final sum is then rounded (half-up), shifted
// right by SHIFT and saturated to DATA_W bits. The accumulator restarts from
// zero for the next frame without an idle cycle.
//
// Pipeline stages:
//   S1  input register      (a, b, sub, last, valid)
//   S2  product register    (2*DATA_W product, extended per SIGNED)
//   S3  accumulator         (final frame sum captured on a last term)
//   S4  output register     (round / shift / saturate of the final sum)
// A last term accepted at edge k is visible on out_valid after edge k+3.
// One global enable freezes every stage while a result waits for out_ready.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   in_valid   term valid           in_ready   term accepted this cycle
//   in_a/in_b  operands             in_sub     subtract this product
//   in_last    final term of frame
//   out_valid  result held          out_ready  downstream accepts result
//   out_data   rounded, saturated result
//   out_acc    raw final accumulator value of the frame
//   out_sat    out_data was clamped
// -----------------------------------------------------------------------------
module mac_dot_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 15,
    parameter int SIGNED = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sub,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat
);

    localparam int PW        = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);

    // Constants in the ACC_W+1 domain, where rounding cannot overflow.
    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] RND_C = (SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] MAX_V = IS_SIGNED ? ((ONE <<< (DATA_W - 1)) - ONE) : ((ONE <<< DATA_W) - ONE);
    localparam logic signed [ACC_W:0] MIN_V = IS_SIGNED ? -(ONE <<< (DATA_W - 1)) : '0;

    // The whole pipeline advances only when no result is stuck at the output.
    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    // ---------------- S1: input register ----------------
    logic              s1_valid, s1_sub, s1_last;
    logic [DATA_W-1:0] s1_a, s1_b;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge CLK) begin
        if (RST)     s1_valid <= 1'b0;
        else if (en) s1_valid <= in_valid;
    end

    // NOTE: payload registers carry no reset; only the valid bits qualify them,
    // which keeps reset fan-out off the wide datapath.
    always_ff @(posedge CLK) begin
        if (en) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_sub  <= in_sub;
            s1_last <= in_last;
        end
    end

    // ---------------- S2: product register ----------------
    logic [PW-1:0] a_ext, b_ext, prod_c;
    // Extending the operands to PW bits first makes the low PW bits of a plain
    // multiply correct for both two's-complement and unsigned operands.
    assign a_ext  = IS_SIGNED ? PW'($signed(s1_a)) : PW'(s1_a);
    assign b_ext  = IS_SIGNED ? PW'($signed(s1_b)) : PW'(s1_b);
    assign prod_c = a_ext * b_ext;

    logic          s2_valid, s2_sub, s2_last;
    logic [PW-1:0] s2_prod;

    always_ff @(posedge CLK) begin
        if (RST)     s2_valid <= 1'b0;
        else if (en) s2_valid <= s1_valid;
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            s2_prod <= prod_c;
            s2_sub  <= s1_sub;
            s2_last <= s1_last;
        end
    end

    // ---------------- S3: accumulator ----------------
    logic [ACC_W-1:0] acc, prod_ext, sum;
    assign prod_ext = IS_SIGNED ? ACC_W'($signed(s2_prod)) : ACC_W'(s2_prod);
    // Wraps modulo 2^ACC_W by construction; no overflow detection here.
    assign sum      = s2_sub ? (acc - prod_ext) : (acc + prod_ext);

    logic             fin_valid;
    logic [ACC_W-1:0] fin_sum;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= '0;
            fin_valid <= 1'b0;
        end else if (en) begin
            fin_valid <= s2_valid & s2_last;
            if (s2_valid) acc <= s2_last ? '0 : sum;
        end
    end

    always_ff @(posedge CLK) begin
        if (en && s2_valid && s2_last) fin_sum <= sum;
    end

    // ---------------- S4: round, shift, saturate ----------------
    logic signed [ACC_W:0] wide, rnd, shd;
    logic [DATA_W-1:0]     data_c;
    logic                  sat_c;

    assign wide = $signed({fin_sum[ACC_W-1], fin_sum});
    assign rnd  = wide + RND_C;
    assign shd  = rnd >>> SHIFT;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        data_c = shd[DATA_W-1:0];
        sat_c  = 1'b0;
        if (shd > MAX_V) begin
            data_c = MAX_V[DATA_W-1:0];
            sat_c  = 1'b1;
        end else if (shd < MIN_V) begin
            data_c = MIN_V[DATA_W-1:0];
            sat_c  = 1'b1;
        end
    end

    // With en=1 any held result is being accepted this edge, so out_valid
    // simply follows fin_valid: reload on a new result, otherwise clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                out_data <= data_c;
                out_acc  <= fin_sum;
                out_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_engine
//
// Directed bench for mac_dot_engine at its default configuration
// (DATA_W=16, ACC_W=40, SHIFT=15, SIGNED=1), plus a randomized handshake run
// checked against an independent integer model of the dot product.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there or
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_mac_dot_engine;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [39:0] out_acc;
    logic        out_sat;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mac_dot_engine #(.DATA_W(16), .ACC_W(40), .SHIFT(15), .SIGNED(1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_acc   (out_acc),
        .out_sat   (out_sat)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] d;
        logic [39:0] a;
        logic        s;
    } res_t;

    res_t exp_q[$];
    bit   stop_drv;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one term and hold it until accepted (bounded).
    task automatic send_term(input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic last);
        bit acc_ok;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            acc_ok = in_ready;
            step();
            if (acc_ok) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count cycles until out_valid is seen (bounded).
    task automatic wait_out(output int cycles, output bit seen);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            step();
            cycles++;
        end
        seen = out_valid;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    // Independent model: 64-bit integer dot product, wrapped to 40 bits,
    // Q15 round-half-up and clamp to int16.
    function automatic res_t model(input longint s);
        res_t        r;
        logic [39:0] a40;
        longint      v, q;
        a40 = s[39:0];
        v   = longint'($signed(a40));
        q   = (v + 64'sd16384) >>> 15;
        r.a = a40;
        r.s = 1'b0;
        if (q > 64'sd32767) begin
            q   = 64'sd32767;
            r.s = 1'b1;
        end else if (q < -64'sd32768) begin
            q   = -64'sd32768;
            r.s = 1'b1;
        end
        r.d = q[15:0];
        return r;
    endfunction

    task automatic test_reset();
        bit saw;
        RST      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h4000;
        in_b     = 16'h4000;
        in_last  = 1'b1;
        repeat (2) step();
        RST      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_sat !== 1'b0 || out_acc !== 40'h0) $display("FAIL reset_sat_acc: got sat=%b acc=%h want 0/0", out_sat, out_acc);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        saw = 1'b0;
        repeat (6) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        total_cnt++;
        if (saw !== 1'b0) $display("FAIL reset_no_accept: out_valid seen %b want 0", saw);
        else pass_cnt++;
    endtask

    task automatic test_q15();
        int cyc;
        bit seen;
        out_ready = 1'b1;
        send_term(16'h4000, 16'h4000, 1'b0, 1'b1);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || cyc != 3) $display("FAIL q15_latency: got %0d cycles (seen=%b) want 3", cyc, seen);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h2000) $display("FAIL q15_data: got %h want 2000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_acc !== 40'h0010000000 || out_sat !== 1'b0) $display("FAIL q15_acc: got acc=%h sat=%b want 0010000000/0", out_acc, out_sat);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL q15_consumed: out_valid %b want 0", out_valid);
        else pass_cnt++;
        send_term(16'h0001, 16'h4000, 1'b0, 1'b1);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_data !== 16'h0001) $display("FAIL q15_round: got %h (seen=%b) want 0001", out_data, seen);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_add_sub();
        int cyc;
        bit seen;
        send_term(16'h4000, 16'h4000, 1'b0, 1'b0);
        send_term(16'h2000, 16'h4000, 1'b1, 1'b1);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_acc !== 40'h0008000000) $display("FAIL addsub_acc: got %h (seen=%b) want 0008000000", out_acc, seen);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'h1000 || out_sat !== 1'b0) $display("FAIL addsub_data: got %h sat=%b want 1000/0", out_data, out_sat);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_saturation();
        int cyc;
        bit seen;
        for (int i = 0; i < 4; i++) send_term(16'h7FFF, 16'h7FFF, 1'b0, i == 3);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_data !== 16'h7FFF || out_sat !== 1'b1) $display("FAIL sat_pos: got %h sat=%b want 7fff/1", out_data, out_sat);
        else pass_cnt++;
        total_cnt++;
        if (out_acc !== 40'h00FFFC0004) $display("FAIL sat_pos_acc: got %h want 00fffc0004", out_acc);
        else pass_cnt++;
        drain();
        for (int i = 0; i < 4; i++) send_term(16'h8000, 16'h7FFF, 1'b0, i == 3);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_data !== 16'h8000 || out_sat !== 1'b1) $display("FAIL sat_neg: got %h sat=%b want 8000/1", out_data, out_sat);
        else pass_cnt++;
        total_cnt++;
        if (out_acc !== 40'hFF00020000) $display("FAIL sat_neg_acc: got %h want ff00020000", out_acc);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen, saw;
        out_ready = 1'b0;
        send_term(16'h4000, 16'h4000, 1'b0, 1'b1);
        send_term(16'h0001, 16'h4000, 1'b0, 1'b1);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_data !== 16'h2000) $display("FAIL bp_first: got %h (seen=%b) want 2000", out_data, seen);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 16'h2000 || out_acc !== 40'h0010000000 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b d=%h acc=%h rdy=%b want 1/2000/0010000000/0",
                         i, out_valid, out_data, out_acc, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001) $display("FAIL bp_second: got v=%b d=%h want 1/0001", out_valid, out_data);
        else pass_cnt++;
        saw = 1'b0;
        repeat (4) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        total_cnt++;
        if (saw !== 1'b0) $display("FAIL bp_no_dup: extra result %b want 0", saw);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        for (int i = 0; i < 3; i++) send_term(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        send_term(16'h4000, 16'h4000, 1'b0, 1'b1);
        wait_out(cyc, seen);
        total_cnt++;
        if (!seen || out_data !== 16'h2000 || out_acc !== 40'h0010000000)
            $display("FAIL reset_mid: got %h acc=%h (seen=%b) want 2000/0010000000", out_data, out_acc, seen);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_random();
        int  rx, cyc;
        res_t e;
        stop_drv = 1'b0;
        exp_q.delete();
        fork
            begin : driver
                for (int f = 0; f < 1000 && !stop_drv; f++) begin
                    int     n;
                    longint s;
                    n = $urandom_range(1, 4);
                    s = 0;
                    for (int t = 0; t < n && !stop_drv; t++) begin
                        logic [15:0] a, b;
                        logic        sb;
                        bit          ok;
                        a  = 16'($urandom());
                        b  = 16'($urandom());
                        sb = 1'($urandom_range(0, 1));
                        if (sb) s = s - longint'($signed(a)) * longint'($signed(b));
                        else    s = s + longint'($signed(a)) * longint'($signed(b));
                        if (t == n - 1) exp_q.push_back(model(s));
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                            step();
                        end
                        in_valid = 1'b1;
                        in_a     = a;
                        in_b     = b;
                        in_sub   = sb;
                        in_last  = (t == n - 1);
                        ok       = 1'b0;
                        while (!ok && !stop_drv) begin
                            @(negedge CLK);
                            ok = in_ready;
                            step();
                        end
                        in_valid = 1'b0;
                        in_last  = 1'b0;
                    end
                end
            end
            begin : monitor
                rx  = 0;
                cyc = 0;
                while (rx < 1000 && cyc < 60000) begin
                    step();
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                    if (out_valid && out_ready) begin
                        total_cnt++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL rand_extra%0d: got %h with no frame expected", rx, out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_data, out_acc, out_sat} !== {e.d, e.a, e.s})
                                $display("FAIL rand_frame%0d: got d=%h acc=%h sat=%b want d=%h acc=%h sat=%b",
                                         rx, out_data, out_acc, out_sat, e.d, e.a, e.s);
                            else pass_cnt++;
                        end
                        rx++;
                    end
                    cyc++;
                end
                stop_drv = 1'b1;
                total_cnt++;
                if (rx != 1000) $display("FAIL rand_timeout: got %0d results want 1000", rx);
                else pass_cnt++;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_q15();
        test_add_sub();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
